// File: rtl/instr_issue_pkg.sv
// Shared opcode constants, field positions, issue states
// and the fetch bundle carried through the issue buffer.
package instr_issue_pkg;

  localparam logic [3:0] OP_JUMP   = 4'd0;
  localparam logic [3:0] OP_RTYPE  = 4'd1;
  localparam logic [3:0] OP_LW     = 4'd2;
  localparam logic [3:0] OP_SW     = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_MAX    = 4'd4;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry FIFO of {pc, instr} with push/pop/flush.
// Ports: push/wdata in, pop, flush, head (zero when empty), count.
module instr_fifo
  import instr_issue_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  fetch_t        wdata,
  input  logic          pop,
  input  logic          flush,
  output fetch_t        head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    count <= FULL
  );

endmodule

// File: rtl/instr_issue.sv
// Fetches instruction words, buffers them and issues opcode/instr/pc
// to decode over valid/ready; handles redirects and halts on bad opcodes.
module instr_issue
  import instr_issue_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  opcode,
  output logic [15:0] instr,
  output logic [15:0] pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        illegal_op
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  issue_state_t  state;
  issue_state_t  state_nxt;
  logic [15:0]   fetch_pc;
  logic [15:0]   req_pc;
  logic          outstanding;
  logic          req_epoch;
  logic          epoch;
  fetch_t        head;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic          has_head;
  logic          head_ok;
  logic          push;
  logic          pop;

  assign has_head    = count != '0;
  assign head_ok     = op_legal(head.instr[OPCODE_MSB:OPCODE_LSB]);
  assign issue_valid = has_head && (state == RUN) && head_ok;
  assign pop         = issue_valid && issue_ready;

  // A pop this cycle frees its slot before the response lands,
  // which is what sustains one instruction per cycle.
  assign credit = {1'b0, count}
                + {{CW{1'b0}}, outstanding}
                - {{CW{1'b0}}, pop};

  assign imem_req  = reset_n && (state == RUN)
                  && !redirect_valid && (credit < LIMIT);
  assign imem_addr = fetch_pc;

  // Stale-epoch or unrequested responses are dropped.
  assign push = imem_rvalid && outstanding && (req_epoch == epoch);

  assign opcode     = head.instr[OPCODE_MSB:OPCODE_LSB];
  assign instr      = head.instr;
  assign pc         = head.pc;
  assign illegal_op = state == HALT;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      req_epoch   <= 1'b0;
      epoch       <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= imem_req;
      if (imem_req) begin
        req_epoch <= epoch;
        req_pc    <= fetch_pc;
        fetch_pc  <= fetch_pc + 16'd1;
      end
      if (redirect_valid) begin
        epoch    <= ~epoch;
        fetch_pc <= redirect_pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      redirect_valid:
        state_nxt = RUN;
      (state == RUN) && has_head && !head_ok:
        state_nxt = HALT;
      default: ;
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ('{pc: req_pc, instr: imem_rdata}),
    .pop     (pop),
    .flush   (redirect_valid),
    .head    (head),
    .count   (count)
  );

endmodule
